ahblite_slave_mux: RTL and testbench

- AHB-Lite response stage directly downstream of the address decoder.
- Registers the decoder's HSEL vector at the address phase.
- Steers the selected slave's HRDATA/HREADYOUT/HRESP back to the Cortex-M0 master during the data phase.
- Contains a built-in default slave that gives the two-cycle AHB ERROR response for unmapped accesses.

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/ahblite_default_slave.sv | 58 +++++
 rtl/ahblite_slave_mux.sv | 125 ++++++++++++
 tb/tb_ahblite_slave_mux.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave index map and default-slave state type
// used by the response-stage multiplexer.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int SLV_RAMCODE    = 0;
    localparam int SLV_RAMDATA    = 1;
    localparam int SLV_WATERLIGHT = 2;
    localparam int SLV_UART       = 3;
    localparam int SLV_DMAC       = 4;
    localparam int SLV_DEF        = 5;
    localparam int NSLV           = 6;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } def_state_t;

endpackage

// File: rtl/ahblite_default_slave.sv
// Built-in default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle AHB ERROR response (wait+ERROR, then ready+ERROR).
module ahblite_default_slave
    import ahb_pkg::*;
#(
    parameter bit EN = 1'b1
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic HREADY,
    input  logic def_sel,
    output logic hreadyout,
    output logic hresp
);

    def_state_t state_reg;
    def_state_t state_next;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg <= DS_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hreadyout  = 1'b1;
        hresp      = HRESP_OKAY;
        case (state_reg)
            DS_IDLE: begin
                if (HREADY && def_sel && EN) begin
                    state_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                hreadyout  = 1'b0;
                hresp      = HRESP_ERROR;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                // Second ERROR cycle completes the transfer, so a new
                // unmapped address may be accepted right here.
                hresp = HRESP_ERROR;
                if (HREADY && def_sel && EN) begin
                    state_next = DS_ERR1;
                end else begin
                    state_next = DS_IDLE;
                end
            end
            default: begin
                state_next = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response stage: registers the decoded select at the address phase
// and steers the owning slave's HRDATA/HREADYOUT/HRESP during the data phase.
module ahblite_slave_mux
    import ahb_pkg::*;
#(
    parameter bit          DEFAULT_SLV_en = 1'b1,
    parameter logic [31:0] DEFAULT_RDATA  = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  HTRANS,
    input  logic        RAMCODE_HSEL,
    input  logic        RAMDATA_HSEL,
    input  logic        WaterLight_HSEL,
    input  logic        UART_HSEL,
    input  logic        DMAC_HSEL,
    input  logic [31:0] HRDATA_RAMCODE,
    input  logic [31:0] HRDATA_RAMDATA,
    input  logic [31:0] HRDATA_WaterLight,
    input  logic [31:0] HRDATA_UART,
    input  logic [31:0] HRDATA_DMAC,
    input  logic        HREADYOUT_RAMCODE,
    input  logic        HREADYOUT_RAMDATA,
    input  logic        HREADYOUT_WaterLight,
    input  logic        HREADYOUT_UART,
    input  logic        HREADYOUT_DMAC,
    input  logic        HRESP_RAMCODE,
    input  logic        HRESP_RAMDATA,
    input  logic        HRESP_WaterLight,
    input  logic        HRESP_UART,
    input  logic        HRESP_DMAC,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int NREAL = NSLV - 1;

    logic [NREAL-1:0] hsel_vec;
    logic [NREAL-1:0] rdy_vec;
    logic [NREAL-1:0] resp_vec;
    logic [31:0]      rdata_arr   [NREAL];
    logic [31:0]      rdata_masked[NREAL];
    logic [NSLV-1:0]  sel_reg;
    logic [NSLV-1:0]  sel_next;
    logic             trans_active;
    logic             def_sel;
    logic             def_hreadyout;
    logic             def_hresp;

    assign hsel_vec  = {DMAC_HSEL, UART_HSEL, WaterLight_HSEL, RAMDATA_HSEL, RAMCODE_HSEL};
    assign rdy_vec   = {HREADYOUT_DMAC, HREADYOUT_UART, HREADYOUT_WaterLight,
                        HREADYOUT_RAMDATA, HREADYOUT_RAMCODE};
    assign resp_vec  = {HRESP_DMAC, HRESP_UART, HRESP_WaterLight,
                        HRESP_RAMDATA, HRESP_RAMCODE};
    assign rdata_arr[SLV_RAMCODE]    = HRDATA_RAMCODE;
    assign rdata_arr[SLV_RAMDATA]    = HRDATA_RAMDATA;
    assign rdata_arr[SLV_WATERLIGHT] = HRDATA_WaterLight;
    assign rdata_arr[SLV_UART]       = HRDATA_UART;
    assign rdata_arr[SLV_DMAC]       = HRDATA_DMAC;

    assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign def_sel      = trans_active && !(|hsel_vec);

    always_comb begin
        sel_next = sel_reg;
        if (HREADY) begin
            sel_next = '0;
            // Walk from lowest priority up so the highest-priority select wins.
            for (int i = NREAL - 1; i >= 0; i--) begin
                if (hsel_vec[i]) begin
                    sel_next    = '0;
                    sel_next[i] = 1'b1;
                end
            end
            if (def_sel) begin
                sel_next[SLV_DEF] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_reg <= '0;
        end else begin
            sel_reg <= sel_next;
        end
    end

    ahblite_default_slave #(
        .EN (DEFAULT_SLV_en)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (HREADY),
        .def_sel   (def_sel),
        .hreadyout (def_hreadyout),
        .hresp     (def_hresp)
    );

    // Gating each bus before the OR keeps unselected slaves out of HRDATA.
    generate
        for (genvar gi = 0; gi < NREAL; gi++) begin : g_rdata_gate
            assign rdata_masked[gi] = sel_reg[gi] ? rdata_arr[gi] : 32'h0;
        end
    endgenerate

    always_comb begin
        HRDATA = DEFAULT_RDATA;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        if (sel_reg[SLV_DEF]) begin
            HREADY = def_hreadyout;
            HRESP  = def_hresp;
        end else if (|sel_reg[NREAL-1:0]) begin
            HRDATA = 32'h0;
            for (int i = 0; i < NREAL; i++) begin
                HRDATA = HRDATA | rdata_masked[i];
            end
            HREADY = |(sel_reg[NREAL-1:0] & rdy_vec);
            HRESP  = |(sel_reg[NREAL-1:0] & resp_vec);
        end
    end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Scoreboard bench: two instances (default slave enabled / disabled) share the
// stimulus; a transfer-level model predicts each cycle's response.
module tb_ahblite_slave_mux;

    typedef struct packed {
        logic             rst;
        logic [1:0]       trans;
        logic [4:0]       hsel;
        logic [4:0][31:0] rdata;
        logic [4:0]       rdy;
        logic [4:0]       resp;
    } stim_t;

    typedef struct packed {
        logic [1:0][31:0] rdata;
        logic [1:0]       rdy;
        logic [1:0]       resp;
    } exp_t;

    logic        clk = 1'b0;
    logic        HRESET;
    logic [1:0]  HTRANS;
    logic [4:0]  hsel;
    logic [4:0][31:0] srdata;
    logic [4:0]  srdy;
    logic [4:0]  sresp;
    logic [31:0] hrdata_a, hrdata_b;
    logic        hready_a, hready_b;
    logic        hresp_a, hresp_b;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Model state per instance: who owns the data phase (-1 nobody, 0..4 a
    // slave, 5 the default slave) and how many ERROR cycles are still due.
    int owner [2];
    int err_left [2];
    bit known = 1'b0;

    always #5 clk = ~clk;

    ahblite_slave_mux #(.DEFAULT_SLV_en(1'b1), .DEFAULT_RDATA(32'h0)) dut_a (
        .HCLK(clk), .HRESET(HRESET), .HTRANS(HTRANS),
        .RAMCODE_HSEL(hsel[0]), .RAMDATA_HSEL(hsel[1]), .WaterLight_HSEL(hsel[2]),
        .UART_HSEL(hsel[3]), .DMAC_HSEL(hsel[4]),
        .HRDATA_RAMCODE(srdata[0]), .HRDATA_RAMDATA(srdata[1]), .HRDATA_WaterLight(srdata[2]),
        .HRDATA_UART(srdata[3]), .HRDATA_DMAC(srdata[4]),
        .HREADYOUT_RAMCODE(srdy[0]), .HREADYOUT_RAMDATA(srdy[1]), .HREADYOUT_WaterLight(srdy[2]),
        .HREADYOUT_UART(srdy[3]), .HREADYOUT_DMAC(srdy[4]),
        .HRESP_RAMCODE(sresp[0]), .HRESP_RAMDATA(sresp[1]), .HRESP_WaterLight(sresp[2]),
        .HRESP_UART(sresp[3]), .HRESP_DMAC(sresp[4]),
        .HRDATA(hrdata_a), .HREADY(hready_a), .HRESP(hresp_a)
    );

    ahblite_slave_mux #(.DEFAULT_SLV_en(1'b0), .DEFAULT_RDATA(32'h0)) dut_b (
        .HCLK(clk), .HRESET(HRESET), .HTRANS(HTRANS),
        .RAMCODE_HSEL(hsel[0]), .RAMDATA_HSEL(hsel[1]), .WaterLight_HSEL(hsel[2]),
        .UART_HSEL(hsel[3]), .DMAC_HSEL(hsel[4]),
        .HRDATA_RAMCODE(srdata[0]), .HRDATA_RAMDATA(srdata[1]), .HRDATA_WaterLight(srdata[2]),
        .HRDATA_UART(srdata[3]), .HRDATA_DMAC(srdata[4]),
        .HREADYOUT_RAMCODE(srdy[0]), .HREADYOUT_RAMDATA(srdy[1]), .HREADYOUT_WaterLight(srdy[2]),
        .HREADYOUT_UART(srdy[3]), .HREADYOUT_DMAC(srdy[4]),
        .HRESP_RAMCODE(sresp[0]), .HRESP_RAMDATA(sresp[1]), .HRESP_WaterLight(sresp[2]),
        .HRESP_UART(sresp[3]), .HRESP_DMAC(sresp[4]),
        .HRDATA(hrdata_b), .HREADY(hready_b), .HRESP(hresp_b)
    );

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = ($urandom_range(99) == 0);
        s.trans = 2'($urandom_range(3));
        case ($urandom_range(3))
            0:       s.hsel = 5'b0;
            1:       s.hsel = 5'($urandom_range(31));
            default: s.hsel = 5'(1 << $urandom_range(4));
        endcase
        for (int i = 0; i < 5; i++) begin
            s.rdata[i] = $urandom;
            s.rdy[i]   = ($urandom_range(3) != 0);
            s.resp[i]  = ($urandom_range(7) == 0);
        end
        return s;
    endfunction

    function automatic stim_t quiet();
        stim_t s;
        s       = rand_stim();
        s.rst   = 1'b0;
        s.trans = 2'b00;
        s.hsel  = 5'b0;
        s.rdy   = 5'b11111;
        s.resp  = 5'b0;
        return s;
    endfunction

    // One bus cycle: apply inputs after the edge, predict the response the
    // master sees this cycle, then advance the model across the next edge.
    task automatic drive(input stim_t s);
        exp_t e;
        int   win;
        @(posedge clk);
        #1;
        HRESET = s.rst; HTRANS = s.trans; hsel = s.hsel;
        srdata = s.rdata; srdy = s.rdy; sresp = s.resp;
        for (int k = 0; k < 2; k++) begin
            e.rdata[k] = 32'h0; e.rdy[k] = 1'b1; e.resp[k] = 1'b0;
            if (owner[k] >= 0 && owner[k] <= 4) begin
                e.rdata[k] = s.rdata[owner[k]];
                e.rdy[k]   = s.rdy[owner[k]];
                e.resp[k]  = s.resp[owner[k]];
            end else if (owner[k] == 5 && err_left[k] > 0) begin
                e.rdy[k]  = (err_left[k] == 1);
                e.resp[k] = 1'b1;
            end
        end
        if (known) exp_q.push_back(e);
        win = -1;
        for (int i = 4; i >= 0; i--) if (s.hsel[i]) win = i;
        for (int k = 0; k < 2; k++) begin
            if (s.rst) begin
                owner[k] = -1; err_left[k] = 0;
            end else if (!known) begin
                // pre-reset state is unknown; keep the model unknown
            end else if (e.rdy[k]) begin
                err_left[k] = 0;
                if (win >= 0) owner[k] = win;
                else if (s.trans[1]) begin
                    owner[k] = 5;
                    err_left[k] = (k == 0) ? 2 : 0;
                end else owner[k] = -1;
            end else if (owner[k] == 5 && err_left[k] == 2) begin
                err_left[k] = 1;
            end
        end
        if (s.rst) known = 1'b1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("en1_hrdata", hrdata_a, e.rdata[0]);
                cmp("en1_hready", {31'b0, hready_a}, {31'b0, e.rdy[0]});
                cmp("en1_hresp",  {31'b0, hresp_a},  {31'b0, e.resp[0]});
                cmp("en0_hrdata", hrdata_b, e.rdata[1]);
                cmp("en0_hready", {31'b0, hready_b}, {31'b0, e.rdy[1]});
                cmp("en0_hresp",  {31'b0, hresp_b},  {31'b0, e.resp[1]});
                $display("cycle t=%0t en1: rd=%h rdy=%b resp=%b  en0: rd=%h rdy=%b resp=%b",
                         $time, hrdata_a, hready_a, hresp_a, hrdata_b, hready_b, hresp_b);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        owner[0] = -1; owner[1] = -1; err_left[0] = 0; err_left[1] = 0;
        HRESET = 1'b1; HTRANS = 2'b00; hsel = 5'b0; srdata = '0; srdy = '1; sresp = '0;

        // reset held two cycles with random slave inputs
        s = rand_stim(); s.rst = 1'b1; drive(s);
        s = rand_stim(); s.rst = 1'b1; drive(s);
        s = quiet(); drive(s);

        // mapped read from RAMDATA; UART data must be ignored
        s = quiet(); s.trans = 2'b10; s.hsel = 5'b00010; drive(s);
        s = quiet(); s.rdata[1] = 32'hDEADBEEF; s.rdata[3] = 32'h12345678; drive(s);

        // UART with three wait states while RAMCODE's address is pending
        s = quiet(); s.trans = 2'b10; s.hsel = 5'b01000; drive(s);
        for (int i = 0; i < 3; i++) begin
            s = quiet(); s.trans = 2'b10; s.hsel = 5'b00001; s.rdy[3] = 1'b0; drive(s);
        end
        s = quiet(); s.trans = 2'b10; s.hsel = 5'b00001; drive(s);
        s = quiet(); drive(s);

        // unmapped access, then back-to-back unmapped issued in ERR2
        s = quiet(); s.trans = 2'b10; drive(s);
        s = quiet(); drive(s);
        s = quiet(); drive(s);
        s = quiet(); drive(s);
        s = quiet(); s.trans = 2'b10; drive(s);
        s = quiet(); drive(s);
        s = quiet(); s.trans = 2'b11; drive(s);
        s = quiet(); drive(s);
        s = quiet(); drive(s);
        s = quiet(); drive(s);

        // IDLE and BUSY with no select stay zero-wait OKAY
        s = quiet(); s.trans = 2'b01; drive(s);
        s = quiet(); drive(s);

        // reset landing in ERR1
        s = quiet(); s.trans = 2'b10; drive(s);
        s = quiet(); s.rst = 1'b1; drive(s);
        s = quiet(); drive(s);

        // RAMCODE beats DMAC
        s = quiet(); s.trans = 2'b10; s.hsel = 5'b10001; drive(s);
        s = quiet(); drive(s);

        // IDLE transfer with a select still forwards that slave
        s = quiet(); s.hsel = 5'b00100; drive(s);
        s = quiet(); drive(s);

        for (int n = 0; n < 3000; n++) begin
            s = rand_stim();
            drive(s);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
